// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiplier and restoring divider share one 2*XLEN
// accumulator. Operands are stored as magnitudes, and the sign is fixed up once
// on the way into DONE. Divide-by-zero and signed overflow take a one-cycle
// fast path.
module alu_muldiv_seq #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   state_e              state_q;
   logic [2:0]          op_q;
   logic                neg_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     opb_q;
   logic                valid_q;
   logic [XLEN-1:0]     result_q;

   // Request decode: operand signedness, magnitudes, result sign, fast paths
   logic                s1, s2;
   logic [XLEN-1:0]     abs1, abs2;
   logic                neg_d;
   logic                fast_d;
   logic [XLEN-1:0]     fast_res_d;
   logic [2*XLEN-1:0]   acc_init_d;
   logic [XLEN-1:0]     opb_init_d;
   logic                div_zero, div_ovf;

   // Decode the incoming request into magnitudes and a single negate flag
   always_comb begin
      s1 = i_op1[XLEN-1] & ((i_op == 3'b001) | (i_op == 3'b010) |
                            (i_op == 3'b100) | (i_op == 3'b110));
      s2 = i_op2[XLEN-1] & ((i_op == 3'b001) | (i_op == 3'b100) |
                            (i_op == 3'b110));
      abs1 = s1 ? ({XLEN{1'b0}} - i_op1) : i_op1;
      abs2 = s2 ? ({XLEN{1'b0}} - i_op2) : i_op2;
      // Remainder follows the dividend's sign; everything else negates on sign mismatch
      neg_d = (i_op[2] & i_op[1]) ? s1 : (s1 ^ s2);
      div_zero = i_op[2] & (i_op2 == '0);
      div_ovf  = i_op[2] & ~i_op[0] &
                 (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_op2 == '1);
      fast_d = div_zero | div_ovf;
      fast_res_d = '0;
      if (div_zero) begin
         fast_res_d = i_op[1] ? i_op1 : '1;
      end else if (div_ovf) begin
         fast_res_d = i_op[1] ? '0 : i_op1;
      end
      // Divide: {rem,quot} starts as {0,|dividend|}; multiply: {hi,lo} starts as {0,|multiplier|}
      acc_init_d = i_op[2] ? {{XLEN{1'b0}}, abs1} : {{XLEN{1'b0}}, abs2};
      opb_init_d = i_op[2] ? abs2 : abs1;
   end

   // One iteration step plus the sign-corrected final result
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_acc;
   logic [XLEN:0]       rem_sh;
   logic                div_ge;
   logic [XLEN-1:0]     rem_sub;
   logic [2*XLEN-1:0]   div_acc;
   logic [2*XLEN-1:0]   acc_d;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     dv, dv_fix;
   logic [XLEN-1:0]     fin_res;

   // Shift-add / restoring-divide datapath for one bit per cycle
   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
      mul_acc = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                         : {1'b0, acc_q[2*XLEN-1:1]};
      // Shifted remainder can exceed XLEN bits, so compare with one extra bit
      rem_sh  = acc_q[2*XLEN-1:XLEN-1];
      div_ge  = rem_sh >= {1'b0, opb_q};
      rem_sub = rem_sh[XLEN-1:0] - opb_q;
      div_acc = div_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                       : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      acc_d   = op_q[2] ? div_acc : mul_acc;

      prod_fix = neg_q ? ({(2*XLEN){1'b0}} - acc_d) : acc_d;
      dv       = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
      dv_fix   = neg_q ? ({XLEN{1'b0}} - dv) : dv;
      if (op_q[2]) begin
         fin_res = dv_fix;
      end else if (op_q[1:0] == 2'b00) begin
         fin_res = prod_fix[XLEN-1:0];
      end else begin
         fin_res = prod_fix[2*XLEN-1:XLEN];
      end
   end

   // Control FSM with registered result/valid; the last iteration edge also
   // applies sign correction so DONE follows exactly XLEN CALC cycles
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid && !i_flush) begin
                  op_q  <= i_op;
                  neg_q <= neg_d;
                  acc_q <= acc_init_d;
                  opb_q <= opb_init_d;
                  if (fast_d) begin
                     state_q  <= DONE;
                     valid_q  <= 1'b1;
                     result_q <= fast_res_d;
                  end else begin
                     state_q <= CALC;
                     cnt_q   <= CNT_W'(XLEN);
                  end
               end
            end
            CALC: begin
               if (i_flush) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q  <= DONE;
                     valid_q  <= 1'b1;
                     result_q <= fin_res;
                  end
               end
            end
            DONE: begin
               if (i_flush || i_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready  = (state_q == IDLE);
   assign o_valid  = valid_q;
   assign o_result = result_q;

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, multi-cycle arithmetic unit for the RV32M/RV64M multiply/divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage; the pipeline stalls on its handshake.
- Uses a radix-2 iterative shift-add multiplier and a restoring divider, one bit per cycle.
- Adds valid/ready handshakes, flush and special-case fast paths, none of which the single-cycle ALU has.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request (high only in IDLE).
- i_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_op1  input  XLEN  rs1 value (multiplicand / dividend).
- i_op2  input  XLEN  rs2 value (multiplier / divisor).
- i_flush  input  1  abort the in-flight operation.
- o_valid  output  1  o_result is valid.
- i_ready  input  1  consumer accepts the result.
- o_result  output  XLEN  result.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (async assert, any state): state=IDLE, o_valid=0, o_result=0, all internal registers=0. o_ready=1 while in IDLE, including during reset.
- Accept: i_valid && o_ready at edge T latches i_op, |i_op1|, |i_op2|, sign flags and the negate-result flag.
  - Normal path: IDLE->CALC; counter=XLEN.
  - Fast path: IDLE->DONE directly.
- Operand signedness:
  - op1 is signed for MULH, MULHSU, DIV, REM.
  - op2 is signed for MULH, DIV, REM.
  - MUL is sign-agnostic: compute it unsigned.
- CALC runs exactly XLEN cycles (T+1..T+XLEN), then goes to DONE.
  - Multiply: 2*XLEN accumulator; each cycle, if the multiplier LSB is set, add the multiplicand to the upper half, then shift right 1.
  - Divide: each cycle shift {rem,quot} left 1; if rem>=divisor, subtract and set quot LSB.
- DONE is entered at T+XLEN+1 on the normal path, at T+1 on the fast path. o_valid=1 in DONE.
- o_result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign correction, applied once when entering DONE:
  - Product is negated (2*XLEN bits) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Fast paths (latency 1):
  - Divide by zero: quotient = all ones; remainder = op1 unmodified.
  - Signed overflow (op1 = most-negative, op2 = -1, DIV/REM only): quotient = op1; remainder = 0.
- Output handshake: in DONE, o_result and o_valid are held stable while i_ready=0. On o_valid && i_ready: state->IDLE, o_valid->0 next cycle.
- No request is accepted in the cycle a result is consumed; o_ready rises the following cycle.
- Flush:
  - i_flush in CALC or DONE: state->IDLE next edge, o_valid->0, no result delivered.
  - i_flush in IDLE takes priority over i_valid, so the request is dropped.
  - Flush wins over i_ready.
- i_op/i_op1/i_op2 changes after acceptance have no effect.
- Reset asserted mid-CALC: outputs reach their reset values immediately; after deassertion the unit is IDLE with o_ready=1.

Test Plan (XLEN=32):
- MUL 7 x 0xFFFFFFFD (-3), accepted at T, i_ready=1 -> o_valid high at T+33 only, o_result=0xFFFFFFEB; o_ready=0 through T+33, 1 at T+34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD at T+33. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at T+1. REM 5/0 -> 5 at T+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM same operands -> 0 at T+1.
- Backpressure: DIV 100/7 with i_ready=0 for 10 cycles after o_valid rises -> o_valid and o_result=14 stable throughout; consumed when i_ready=1, then o_valid=0 and o_ready=1 the next cycle.
- Flush at T+5 of a MUL -> IDLE at T+6, o_valid never rises. Reset pulsed at T+10 of a DIV (asynchronous, mid-cycle) -> o_valid=0, o_result=0 immediately, o_ready=1. A new MUL 3 x 4 afterwards returns 12.
